// File: rtl/camera_init_seq.sv
// camera_init_seq
//   Walks an init table (external synchronous ROM, 1-cycle read latency) and
//   issues one SCCB register write per entry through an external writer.
//   A NACKed write is retried up to MAX_RETRY times with a 1-cycle gap; a
//   settle delay follows the entry at DELAY_AFTER_INDEX (sensor soft reset).
//
// Ports
//   clk, reset   system clock, asynchronous active-high reset
//   start        pulse; (re)starts the sequence from IDLE, DONE or ERROR
//   rom_addr     table address (current entry index)
//   rom_q        table word {reg_addr[15:0], data[7:0]}, 1 cycle after rom_addr
//   wr_req       write request level, high only while a write is outstanding
//   wr_dev_id    SCCB write device address
//   wr_reg_addr  register address of the current entry
//   wr_data      register data of the current entry
//   wr_done      pulse: current write finished
//   wr_nack      qualified by wr_done; 1 = write failed
//   busy         sequence in progress
//   init_done    sticky: all entries written
//   init_error   sticky: retry limit exhausted
module camera_init_seq #(
  parameter int unsigned TABLE_LEN         = 252,
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned DELAY_AFTER_INDEX = 1,
  parameter int unsigned DELAY_CYCLES      = 250000,
  parameter int unsigned MAX_RETRY         = 3,
  parameter logic [7:0]  DEVICE_ID         = 8'h78
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  output logic                  wr_req,
  output logic [7:0]            wr_dev_id,
  output logic [15:0]           wr_reg_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_done,
  input  logic                  wr_nack,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_error
);

  localparam int unsigned DCNT_W = ($clog2(DELAY_CYCLES + 1) > 18) ? $clog2(DELAY_CYCLES + 1) : 18;
  localparam int unsigned RCNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(TABLE_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] DLY_IDX   = ADDR_WIDTH'(DELAY_AFTER_INDEX);
  localparam logic [DCNT_W-1:0]     DCNT_LAST = DCNT_W'(DELAY_CYCLES - 1);
  localparam logic [RCNT_W-1:0]     RETRY_MAX = RCNT_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WRITE,
    S_GAP,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [RCNT_W-1:0]     r_retry;
  logic [DCNT_W-1:0]     r_dcnt;
  logic                  r_wr_req;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [15:0]           r_reg_addr;
  logic [7:0]            r_data;

  assign rom_addr    = r_index;
  assign wr_req      = r_wr_req;
  assign wr_dev_id   = DEVICE_ID;
  assign wr_reg_addr = r_reg_addr;
  assign wr_data     = r_data;
  assign busy        = r_busy;
  assign init_done   = r_done;
  assign init_error  = r_err;

  // Outputs are registered alongside the state: each transition sets the
  // values that belong to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_retry    <= '0;
      r_dcnt     <= '0;
      r_wr_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_reg_addr <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_index <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        // rom_addr has been stable since entering FETCH; rom_q is valid here.
        S_FETCH: r_state <= S_LATCH;

        S_LATCH: begin
          r_reg_addr <= rom_q[23:8];
          r_data     <= rom_q[7:0];
          r_wr_req   <= 1'b1;
          r_state    <= S_WRITE;
        end

        S_WRITE: begin
          if (wr_done) begin
            r_wr_req <= 1'b0;
            if (!wr_nack) begin
              r_retry <= '0;
              if ((r_index == DLY_IDX) && (DELAY_CYCLES != 0)) begin
                r_dcnt  <= '0;
                r_state <= S_DELAY;
              end else begin
                r_state <= S_NEXT;
              end
            end else if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_GAP;
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_ERROR;
            end
          end
        end

        // Re-issue the latched entry; no ROM re-fetch needed.
        S_GAP: begin
          r_wr_req <= 1'b1;
          r_state  <= S_WRITE;
        end

        S_DELAY: begin
          if (r_dcnt == DCNT_LAST) begin
            r_dcnt  <= '0;
            r_state <= S_NEXT;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end

        S_NEXT: begin
          if (r_index == LAST_IDX) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_wr_req <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_init_seq.sv
module tb_camera_init_seq;

  localparam int TL  = 4;
  localparam int DAI = 1;
  localparam int DC  = 10;
  localparam int MR  = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rom_addr;
  logic [23:0] rom_q;
  logic        wr_req;
  logic [7:0]  wr_dev_id;
  logic [15:0] wr_reg_addr;
  logic [7:0]  wr_data;
  logic        wr_done;
  logic        wr_nack;
  logic        busy;
  logic        init_done;
  logic        init_error;

  camera_init_seq #(
    .TABLE_LEN(TL),
    .ADDR_WIDTH(8),
    .DELAY_AFTER_INDEX(DAI),
    .DELAY_CYCLES(DC),
    .MAX_RETRY(MR),
    .DEVICE_ID(8'h78)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .wr_req(wr_req),
    .wr_dev_id(wr_dev_id),
    .wr_reg_addr(wr_reg_addr),
    .wr_data(wr_data),
    .wr_done(wr_done),
    .wr_nack(wr_nack),
    .busy(busy),
    .init_done(init_done),
    .init_error(init_error)
  );

  typedef struct {
    logic [23:0] word;
    int          gap;   // expected wr_req-low cycles before this attempt; -1 = don't care
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] tbl[TL];
  int          plan[TL];    // number of NACKs the writer gives each entry
  int          w_att[TL];
  bit          fixed_lat;
  bit          exp_done;
  bit          exp_err;
  int          tests = 0;
  int          fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, 1-cycle read latency
  always @(posedge clk) rom_q <= tbl[rom_addr[1:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Writer model: answers each request after a latency, NACKing according to plan
  initial begin
    bit w_active;
    int w_cnt;
    int idx;
    w_active = 0;
    w_cnt    = 0;
    wr_done  = 1'b0;
    wr_nack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (reset) begin
        w_active = 0;
        continue;
      end
      if (!w_active && wr_req) begin
        w_active = 1;
        w_cnt    = fixed_lat ? 5 : int'($urandom_range(1, 6));
      end
      if (w_active) begin
        w_cnt--;
        if (w_cnt <= 0) begin
          idx = int'(rom_addr[1:0]);
          w_att[idx]++;
          wr_done  = 1'b1;
          wr_nack  = (w_att[idx] <= plan[idx]);
          w_active = 0;
        end
      end
    end
  end

  // Monitor: every new write attempt pops the scoreboard
  initial begin
    bit          prev;
    int          lowc;
    logic [23:0] cur;
    exp_t        e;
    prev = 0;
    lowc = 0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 0;
        lowc = 0;
        continue;
      end
      if (wr_req && !prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write actual=%h expected=none", {wr_reg_addr, wr_data});
        end else begin
          e   = exp_q.pop_front();
          cur = e.word;
          chk("write_word", {8'h0, wr_reg_addr, wr_data}, {8'h0, e.word});
          if (e.gap >= 0) chk("gap_cycles", lowc, e.gap);
          chk("dev_id", {24'h0, wr_dev_id}, 32'h78);
        end
      end else if (wr_req) begin
        chk("held_stable", {8'h0, wr_reg_addr, wr_data}, {8'h0, cur});
      end
      if (!wr_req) lowc++;
      else lowc = 0;
      prev = wr_req;
    end
  end

  // Reference model: the ordered list of write attempts implied by the table and NACK plan
  task automatic build_expect();
    int gap;
    int tries;
    gap      = -1;
    exp_done = 0;
    exp_err  = 0;
    for (int i = 0; i < TL; i++) begin
      tries = (plan[i] > MR) ? MR + 1 : plan[i] + 1;
      for (int a = 0; a < tries; a++) begin
        exp_q.push_back('{tbl[i], gap});
        gap = 1;
      end
      if (plan[i] > MR) begin
        exp_err = 1;
        return;
      end
      gap = (i == DAI) ? 3 + DC : 3;
    end
    exp_done = 1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_seq(input int poke_idx);
    bit poked;
    bit ok;
    build_expect();
    for (int i = 0; i < TL; i++) w_att[i] = 0;
    pulse_start();
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_done_clr", {31'h0, init_done}, 32'h0);
    chk("start_err_clr", {31'h0, init_error}, 32'h0);
    chk("start_addr", {24'h0, rom_addr}, 32'h0);
    poked = 0;
    ok    = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (start) start = 1'b0;
      if (poke_idx >= 0 && !poked && wr_req && int'(rom_addr) == poke_idx) begin
        start = 1'b1;
        poked = 1;
        continue;
      end
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL seq_timeout actual=busy expected=idle");
    end
    chk("init_done", {31'h0, init_done}, {31'h0, exp_done});
    chk("init_error", {31'h0, init_error}, {31'h0, exp_err});
    chk("attempts_left", exp_q.size(), 0);
    chk("wr_req_idle", {31'h0, wr_req}, 32'h0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < TL; i++) plan[i] = 0;
  endtask

  initial begin
    int r;
    bit ok;
    reset     = 1'b1;
    start     = 1'b0;
    fixed_lat = 1;
    for (int i = 0; i < TL; i++) tbl[i] = {16'h3000 + 16'(i), 8'hA0 + 8'(i)};
    clear_plan();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_req", {31'h0, wr_req}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, init_done}, 32'h0);
    chk("rst_error", {31'h0, init_error}, 32'h0);
    chk("rst_addr", {24'h0, rom_addr}, 32'h0);
    chk("rst_dev_id", {24'h0, wr_dev_id}, 32'h78);
    chk("rst_reg_addr", {16'h0, wr_reg_addr}, 32'h0);
    chk("rst_data", {24'h0, wr_data}, 32'h0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_wr_req", {31'h0, wr_req}, 32'h0);

    // nominal, writer acks 5 cycles after request
    run_seq(-1);
    // start while writing entry 3 (also a restart from DONE)
    run_seq(3);
    // NACK first attempt of entry 2
    plan[2] = 1;
    run_seq(-1);
    // retry exhaustion on entry 0
    clear_plan();
    plan[0] = MR + 1;
    run_seq(-1);
    chk("err_busy", {31'h0, busy}, 32'h0);
    // recovery from ERROR
    clear_plan();
    run_seq(-1);

    // reset in the middle of the settle delay
    build_expect();
    for (int i = 0; i < TL; i++) w_att[i] = 0;
    pulse_start();
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (wr_done && !wr_nack && rom_addr == 8'd1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL delay_entry_timeout actual=none expected=entry1_ack");
    end
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wr_req", {31'h0, wr_req}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_addr", {24'h0, rom_addr}, 32'h0);
    chk("mid_rst_data", {24'h0, wr_data}, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'h0, busy}, 32'h0);
    run_seq(-1);

    // randomized tables, NACK plans and writer latencies
    fixed_lat = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < TL; i++) begin
        tbl[i] = 24'($urandom);
        r = int'($urandom_range(0, 9));
        plan[i] = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : int'($urandom_range(3, 4));
      end
      run_seq(-1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/camera_init_seq.md
CAMERA_INIT_SEQ -- requirements
Module: camera_init_seq

Interface
REQ-001 SHALL have parameter TABLE_LEN, default 252, giving the number of init-table entries to write (indices 0..TABLE_LEN-1).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, giving the table-address width.
REQ-003 SHALL have parameter DELAY_AFTER_INDEX, default 1, giving the entry index after whose successful write a settle delay is inserted (software reset).
REQ-004 SHALL have parameter DELAY_CYCLES, default 250000, giving the settle-delay length in clk cycles (5 ms at 50 MHz).
REQ-005 SHALL have parameter MAX_RETRY, default 3, giving the maximum number of re-issues per entry after a NACK.
REQ-006 SHALL have parameter DEVICE_ID, default 8'h78, giving the SCCB write device address.
REQ-007 SHALL have ports as follows; clock and reset use the codebase's standard names, with one clock and an asynchronous, active-high reset:
  clk          input   1           system clock
  reset        input   1           asynchronous active-high reset
  start        input   1           single-cycle pulse that begins the init sequence
  rom_addr     output  ADDR_WIDTH  init-table address
  rom_q        input   24          table word {reg_addr[15:0], data[7:0]}, valid 1 cycle after rom_addr
  wr_req       output  1           write request, level
  wr_dev_id    output  8           SCCB device ID
  wr_reg_addr  output  16          register address
  wr_data      output  8           register data
  wr_done      input   1           single-cycle pulse marking completion of the current write
  wr_nack      input   1           qualified by wr_done; 1 = write failed
  busy         output  1           1 in every state except IDLE, DONE and ERROR
  init_done    output  1           all entries written successfully
  init_error   output  1           retry limit exhausted

Function
REQ-008 SHALL implement states IDLE, FETCH, LATCH, WRITE, GAP, DELAY, NEXT, DONE and ERROR, with state transitions taken on the clk edge.
REQ-009 SHALL, on start=1 in IDLE, DONE or ERROR: clear index, retry count, init_done and init_error, and enter FETCH.
REQ-010 SHALL ignore start in all other states.
REQ-011 SHALL drive rom_addr = index continuously, and hold it stable from FETCH through NEXT.
REQ-012 SHALL spend exactly one cycle in FETCH to cover the ROM's 1-cycle latency, then enter LATCH.
REQ-013 SHALL, in LATCH, register wr_reg_addr = rom_q[23:8] and wr_data = rom_q[7:0], then enter WRITE.
REQ-014 SHALL assert wr_req=1 only in WRITE, with wr_dev_id, wr_reg_addr and wr_data stable for as long as wr_req=1.
REQ-015 SHALL, in WRITE on wr_done=1 with wr_nack=0: clear the retry count, then go to DELAY if index==DELAY_AFTER_INDEX, otherwise to NEXT.
REQ-016 SHALL, in WRITE on wr_done=1 with wr_nack=1: if retry count < MAX_RETRY, increment it and enter GAP; otherwise enter ERROR.
REQ-017 SHALL hold wr_req=0 for exactly one cycle in GAP, then return to WRITE and re-issue the same entry without re-fetching.
REQ-018 SHALL ignore wr_done and wr_nack outside WRITE.
REQ-019 SHALL, in DELAY, count exactly DELAY_CYCLES cycles with a counter of at least 18 bits sized from DELAY_CYCLES, then enter NEXT.
REQ-020 SHALL, in NEXT: enter DONE if index==TABLE_LEN-1; otherwise increment index and enter FETCH.
REQ-021 SHALL never wrap index past TABLE_LEN-1.
REQ-022 SHALL hold init_done=1 in DONE and init_error=1 in ERROR, both being sticky until the next start or reset.
REQ-023 SHALL yield, for an entry with no NACK and no delay, a per-entry overhead of 3 cycles (FETCH, LATCH, NEXT) plus the writer latency.

Reset
REQ-024 SHALL, on reset=1 (asynchronous, taking effect in any state including mid-write or mid-delay): enter IDLE and drive wr_req=0, busy=0, init_done=0, init_error=0, rom_addr=0, wr_dev_id=DEVICE_ID, wr_reg_addr=0, wr_data=0, and clear the retry and delay counters.
REQ-025 SHALL, after reset is released, remain in IDLE until start=1.

Verification
REQ-026 SHALL pass the nominal sequence: with TABLE_LEN=4, DELAY_AFTER_INDEX=1, DELAY_CYCLES=10, a ROM model and a writer acking 5 cycles after wr_req -> exactly 4 writes in address order, wr_req stays low for 10 cycles after the second write, and init_done=1 after the last write.
REQ-027 SHALL pass a NACK with recovery: NACK the first attempt of entry 2 -> wr_req low for 1 cycle, then the same {reg_addr, data} is re-issued and the sequence completes with init_done=1.
REQ-028 SHALL pass retry exhaustion: with MAX_RETRY=3, NACK every attempt of entry 0 -> 4 total attempts, then init_error=1, busy=0, and no write to entry 1.
REQ-029 SHALL pass a mid-operation reset: assert reset while in DELAY -> wr_req=0 and busy=0 immediately; a subsequent start restarts at rom_addr=0.
REQ-030 SHALL pass start while busy: pulse start during WRITE of entry 3 -> no effect, and the write order is unchanged.
REQ-031 SHALL pass restart from DONE: pulse start in DONE -> init_done clears the next cycle and all TABLE_LEN entries are rewritten.
